// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transceiver and its controllers.
//   - Default byte width for the request/transmit data paths.
//   - Transmit-controller state encodings.
//   - The 2-bit baud-select encodings understood by serial_transceiver.
//   - max_u(): helper used to size the shared timing counter.
package serial_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  localparam logic [1:0] RATE_9600    = 2'd0;
  localparam logic [1:0] RATE_19200   = 2'd1;
  localparam logic [1:0] RATE_57600   = 2'd2;
  localparam logic [1:0] RATE_115200  = 2'd3;
  localparam logic [1:0] RATE_DEFAULT = RATE_9600;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, reset  : clock, asynchronous active-high reset (pointer -> 0)
//   valid0_i/1_i: request lines
//   advance_i   : a grant was taken this cycle; pointer moves past the winner
//   sel_o       : combinational winner index
//   ptr_o       : current priority pointer
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic advance_i,
  output logic sel_o,
  output logic ptr_o
);

  logic ptr_q;

  // A lone requester wins outright; with both or neither, the pointer decides.
  always_comb begin
    sel_o = ptr_q;
    if (valid0_i ^ valid1_i) begin
      sel_o = valid1_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (advance_i) begin
      ptr_q <= ~sel_o;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: shares one serial transmitter between two byte sources.
// Frames are sequenced as start pulse -> wait busy -> wait idle -> gap; the
// baud select is only allowed to follow cfg_rate while idle.
//   clk, reset           : clock, asynchronous active-high reset
//   reqN_valid/data/ready: source N byte handshake (ready is combinational)
//   cfg_rate             : requested baud select
//   rate_sel             : baud select to the transceiver (frozen mid-frame)
//   tx_start             : one-cycle frame start pulse
//   tx_data              : byte to transmit, stable for the whole frame
//   tx_busy              : transceiver shifting a frame
//   grant                : owner of the current / most recent frame
//   err                  : one-cycle pulse when busy fails to rise in time
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned ACK_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic [1:0]            cfg_rate,
  output logic [1:0]            rate_sel,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy,
  output logic                  grant,
  output logic                  err
);

  localparam int unsigned CNT_MAX    = max_u(GAP_CYCLES, ACK_TIMEOUT);
  localparam int unsigned CW         = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned ACK_LAST_I = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;
  localparam int unsigned GAP_LAST_I = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
  localparam logic [CW-1:0] ACK_LAST = ACK_LAST_I[CW-1:0];
  localparam logic [CW-1:0] GAP_LAST = GAP_LAST_I[CW-1:0];

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [1:0]            rate_q, rate_d;
  logic                  grant_q, grant_d;
  logic                  start_q, start_d;
  logic                  err_q, err_d;
  logic                  sel;
  logic                  ptr;
  logic                  in_idle;
  logic                  handshake;

  assign in_idle   = (state_q == ST_IDLE);
  assign handshake = in_idle && (sel ? req1_valid : req0_valid);

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .valid0_i  (req0_valid),
    .valid1_i  (req1_valid),
    .advance_i (handshake),
    .sel_o     (sel),
    .ptr_o     (ptr)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    rate_d    = rate_q;
    grant_d   = grant_q;
    start_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rate_d = cfg_rate;
        if (handshake) begin
          tx_data_d = sel ? req1_data : req0_data;
          grant_d   = sel;
          start_d   = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == ACK_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every state entry starts the shared counter from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      rate_q    <= RATE_DEFAULT;
      grant_q   <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      rate_q    <= rate_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      err_q     <= err_d;
    end
  end

  assign req0_ready = in_idle && !sel;
  assign req1_ready = in_idle && sel;
  assign rate_sel   = rate_q;
  assign tx_start   = start_q;
  assign tx_data    = tx_data_q;
  assign grant      = grant_q;
  assign err        = err_q;

  logic unused_ptr;
  assign unused_ptr = ptr;

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Transmit-side controller for `serial_transceiver`. It shares the single serial transmitter between two byte producers using round-robin arbitration. It sequences each frame as start pulse, then wait for busy, then wait for idle, then an inter-frame gap. It also owns the transceiver's 2-bit baud select, which may change only between frames. It sits between the application-side byte sources and the transceiver's parallel transmit port.

## Interface
- `DATA_WIDTH`, 8: byte width of the request and transmit data.
- `GAP_CYCLES`, 16: idle clock cycles enforced after each frame; 0 means no gap.
- `ACK_TIMEOUT`, 32: cycles allowed for `tx_busy` to rise after `tx_start`.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: source 0 has a byte.
- `req0_data` in DATA_WIDTH: source 0 byte.
- `req0_ready` out 1: source 0 byte accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: the same three signals for source 1.
- `cfg_rate` in 2: requested baud select.
- `rate_sel` out 2: baud select driven to the transceiver.
- `tx_start` out 1: one-cycle frame start pulse to the transceiver.
- `tx_data` out DATA_WIDTH: byte to the transceiver, held stable for the whole frame.
- `tx_busy` in 1: transceiver is shifting a frame.
- `grant` out 1: index of the source that owns the current or most recent frame.
- `err` out 1: one-cycle pulse when an `ACK_TIMEOUT` expires.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- **Arbitration (IDLE only)**
  - `sel` is the single valid source when only one is valid.
  - `sel` is `ptr` when both are valid or neither is valid.
  - `reqN_ready` is combinational: `state==IDLE && sel==N`. It is never high outside IDLE. It is never high for both sources at once.
- **Handshake**
  - A transfer happens on an edge where the selected source has `valid && ready`.
  - That edge loads `tx_data` from the source data, sets `grant=sel`, sets `ptr=~sel`, and moves to START.
- **START**: `tx_start=1` for exactly this one cycle, then go to WAIT_BUSY with the timeout counter cleared.
- **WAIT_BUSY**
  - `tx_busy=1` → go to WAIT_DONE.
  - Counter reaches `ACK_TIMEOUT-1` with `tx_busy` still low → pulse `err` one cycle and go to IDLE.
- **WAIT_DONE**: `tx_busy=0` → go to GAP if `GAP_CYCLES>0`, else go to IDLE.
- **GAP**: count exactly `GAP_CYCLES` cycles, then go to IDLE.
- **rate_sel**: loaded from `cfg_rate` on every clock edge while in IDLE; frozen in all other states. A `cfg_rate` change mid-frame takes effect on the first edge after returning to IDLE.
- **Counters**: one shared counter of width `$clog2(max(GAP_CYCLES, ACK_TIMEOUT)+1)`. It is cleared on every state entry. It never wraps.

## Timing
- Reset values, applied asynchronously:
  - state IDLE, `ptr=0`, `grant=0`.
  - `tx_start=0`, `tx_data=0`, `rate_sel=0`, `err=0`, counter 0.
- Handshake at edge E0 → `tx_start` is high in the cycle after E0.
- Earliest `tx_busy` sample is in the cycle after `tx_start`.
- Back-to-back frames: next handshake edge comes no earlier than `GAP_CYCLES+1` edges after `tx_busy` is sampled low.
- Valid deasserted before the handshake edge: no transfer and no pointer change; valid need not stay asserted.
- `reset` mid-frame: immediate return to reset values. Any byte already accepted is dropped with no retry.
- `tx_busy` already high in START is ignored; it is first sampled in WAIT_BUSY.

## Structure
- Shared package `serial_pkg`: state encoding constants, the 2-bit rate-select encodings shared with the transceiver, and the default `DATA_WIDTH`.
- One sub-module, `rr_arb2`, containing the two-requester combinational select and the `ptr` update, so the same arbiter can be reused on the receive side.
- The FSM, counter and output registers live in `serial_tx_arbiter`.

## Test plan
All scenarios use `GAP_CYCLES=4` and `ACK_TIMEOUT=8`. The transceiver model raises busy 1 cycle after `tx_start` and holds it for 10 cycles.

- Reset with both sources valid → `tx_start=0`, `rate_sel=0`, `req0_ready=1` in the first IDLE cycle; source 0 is served first.
- Both sources continuously valid, `req0_data=0x35`, `req1_data=0xCA` → `tx_data` alternates 0x35, 0xCA, 0x35 and `grant` alternates 0, 1, 0. Each frame has exactly one `tx_start` pulse, and the following `reqN_ready` rises 4 cycles after busy falls.
- Only source 1 valid, three bytes 0x01/0x02/0x03 → all three are accepted in order with `grant=1`, and `req0_ready` stays 0 throughout.
- Transceiver model never raises busy → `err` pulses once, 8 cycles after the WAIT_BUSY entry. The FSM returns to IDLE and the next request is accepted.
- `cfg_rate` changed from 0 to 2 mid-frame → `rate_sel` stays 0 until the frame and gap complete, then reads 2 from the first IDLE edge onward.
- `reset` asserted during WAIT_DONE → all outputs return to their reset values immediately; after release, `ptr=0` and source 0 is served first.
